// File: rtl/imem_loader.sv
// Byte-stream to word-write loader for the big-endian instruction memory.
// Packs four accepted bytes MSB-first into one 32-bit write at consecutive word addresses.
module imem_loader #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [7:0]  words_left_q, words_left_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q, shift_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept_s;
    logic        last_byte_s;
    logic [33:0] range_end_s;
    logic        cfg_bad_s;

    // 34-bit end address so a huge base cannot wrap past the bounds check.
    assign range_end_s = {2'b00, base_addr} + {24'd0, word_count, 2'b00};
    assign cfg_bad_s   = (base_addr[1:0] != 2'b00) || (range_end_s > 34'(MEM_BYTES));
    assign accept_s    = in_valid && in_ready_q;
    assign last_byte_s = (byte_idx_q == 2'd3);

    // State register and registered status/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (accept_s && last_byte_s && (words_left_q == 8'd1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_IDLE, S_DONE, S_ERR: begin
                if (!start) begin
                    state_d = state_q;
                end else if (cfg_bad_s) begin
                    state_d = S_ERR;
                end else if (word_count == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register in step with state_q.
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            S_LOAD:  begin in_ready_d = 1'b1; busy_d = 1'b1; end
            S_DONE:  done_d  = 1'b1;
            S_ERR:   error_d = 1'b1;
            S_IDLE:  busy_d  = 1'b0;
            default: busy_d  = 1'b0;
        endcase
    end

    // Datapath next values: load setup, byte packing and word write issue.
    always_comb begin
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if ((state_q != S_LOAD) && (state_d == S_LOAD)) begin
            cur_addr_d   = base_addr;
            words_left_d = word_count;
            byte_idx_d   = 2'd0;
            shift_d      = 24'd0;
        end else if (accept_s) begin
            if (last_byte_s) begin
                wr_en_d      = 1'b1;
                wr_addr_d    = cur_addr_q;
                wr_data_d    = {shift_q, in_data};
                cur_addr_d   = cur_addr_q + 32'd4;
                words_left_d = words_left_q - 8'd1;
                byte_idx_d   = 2'd0;
            end else begin
                shift_d    = {shift_q[15:0], in_data};
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q   <= 32'd0;
            words_left_q <= 8'd0;
            byte_idx_q   <= 2'd0;
            shift_q      <= 24'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: packing, gaps, bounds errors, empty load, reset recovery.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [7:0]  word_count = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready, wr_en, busy, done, error;
    logic [31:0] wr_addr, wr_data;

    int total = 0;
    int bad = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  prog[8];

    imem_loader #(.MEM_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every write strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [7:0] n);
        base_addr = b; word_count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = b;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("byte_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wen"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, error}, 32'd0);
        check({tag, "_waddr"}, wr_addr, 32'd0);
        check({tag, "_wdata"}, wr_data, 32'd0);
    endtask

    initial begin
        prog[0] = 8'h00; prog[1] = 8'h01; prog[2] = 8'h28; prog[3] = 8'h20;
        prog[4] = 8'h00; prog[5] = 8'h22; prog[6] = 8'h30; prog[7] = 8'h20;

        // Reset state
        #1;
        check_idle_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Two words back-to-back at 0x00
        do_start(32'h0, 8'd2);
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_rdy", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_rdy_low", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t2_nwr", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check("t2_a0", wa_q[0], 32'h0000_0000);
            check("t2_d0", wd_q[0], 32'h0001_2820);
            check("t2_a1", wa_q[1], 32'h0000_0004);
            check("t2_d1", wd_q[1], 32'h0022_3020);
        end
        wa_q.delete(); wd_q.delete();

        // Same stream with 1-3 cycle valid gaps; single-cycle strobe after each 4th byte
        do_start(32'h0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], (i % 3) + 1);
            if (i == 3) check("t3_wen_w0", {31'd0, wr_en}, 32'd1);
            if (i == 4) check("t3_wen_off", {31'd0, wr_en}, 32'd0);
        end
        check("t3_wen_w1", {31'd0, wr_en}, 32'd1);
        check("t3_done", {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
        check("t3_nwr", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            check("t3_a0", wa_q[0], 32'h0000_0000);
            check("t3_d0", wd_q[0], 32'h0001_2820);
            check("t3_a1", wa_q[1], 32'h0000_0004);
            check("t3_d1", wd_q[1], 32'h0022_3020);
        end
        wa_q.delete(); wd_q.delete();

        // Misaligned base, then overflow past the top, then an exact fit at 0xFC
        do_start(32'h2, 8'd1);
        check("t4_mis_err", {31'd0, error}, 32'd1);
        check("t4_mis_rdy", {31'd0, in_ready}, 32'd0);
        check("t4_mis_done", {31'd0, done}, 32'd0);
        do_start(32'h0, 8'd1);
        check("t4_ok_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        check("t4_ok_done", {31'd0, done}, 32'd1);
        do_start(32'hFC, 8'd2);
        check("t4_ovf_err", {31'd0, error}, 32'd1);
        check("t4_ovf_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("t4_err_hold", {31'd0, error}, 32'd1);
        do_start(32'hFFFF_FFFC, 8'd1);
        check("t4_wrap_err", {31'd0, error}, 32'd1);
        wa_q.delete(); wd_q.delete();
        do_start(32'hFC, 8'd1);
        check("t4_top_busy", {31'd0, busy}, 32'd1);
        check("t4_top_err", {31'd0, error}, 32'd0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        check("t4_top_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("t4_top_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check("t4_top_a", wa_q[0], 32'h0000_00FC);
            check("t4_top_d", wd_q[0], 32'hDEAD_BEEF);
        end
        wa_q.delete(); wd_q.delete();

        // Empty load from ERR
        do_start(32'h3, 8'd1);
        check("t5_pre_err", {31'd0, error}, 32'd1);
        do_start(32'h40, 8'd0);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_err", {31'd0, error}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t5_rdy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check("t5_nwr", wa_q.size(), 32'd0);

        // Reset mid-word, then a clean restart at 0x10
        do_start(32'h0, 8'd1);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa_q.delete(); wd_q.delete();
        do_start(32'h10, 8'd1);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
        check("t6_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check("t6_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            check("t6_a", wa_q[0], 32'h0000_0010);
            check("t6_d", wd_q[0], 32'h1122_3344);
        end

        // start during LOAD is ignored
        do_start(32'h20, 8'd1);
        send_byte(8'h55, 0);
        do_start(32'h2, 8'd1);
        check("t7_ign_busy", {31'd0, busy}, 32'd1);
        check("t7_ign_err", {31'd0, error}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
